uart_frame_sender: RTL and testbench

- Parametrised frame transmitter for the UART path to the PC.
- Latches a wide frame (NBYTES bytes), serialises it MSB-byte-first into a byte-level UART transmitter through a valid/ready handshake, and signals completion.
- Supports single-shot and periodic repeat with a programmable inter-frame gap, graceful stop, and frame counting.
- Sits between the pattern/data source and the byte UART TX core.

---
 rtl/uart_frame_sender_if.sv | 10 +
 rtl/uart_frame_sender.sv | 171 +++++++++++++++++
 tb/tb_uart_frame_sender.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_sender_if.sv
// Byte-stream handshake between the frame sender and the byte UART TX core.
// A byte moves on any clock edge where tx_valid and tx_ready are both high.
interface uart_frame_sender_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_frame_sender.sv
// Latches an NBYTES-wide frame and streams it MSB byte first into a byte UART,
// with optional periodic repeat, a programmable inter-frame gap and a graceful stop.
module uart_frame_sender #(
    parameter int NBYTES = 5,
    parameter int GAP_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  repeat_en,
    input  logic [GAP_W-1:0]      gap_cycles,
    input  logic [8*NBYTES-1:0]   frame_in,
    uart_frame_sender_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [2:0]            sta
);

    localparam int FW    = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 2) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [FW-1:0]       shift_r;
    logic [IDX_W-1:0]    byte_idx_r;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic                stop_lat_r;
    logic                tx_valid_r;
    logic [7:0]          tx_data_r;
    logic                done_r;
    logic                busy_r;
    logic [CNT_W-1:0]    frame_cnt_r;
    logic                xfer_s;
    logic                last_s;
    logic                stop_any_s;

    assign xfer_s     = (state_r == ST_SEND) && tx_valid_r && bus.tx_ready;
    assign last_s     = (byte_idx_r == IDX_W'(NBYTES - 1));
    // A stop arriving on the same edge as the last byte still prevents the gap.
    assign stop_any_s = stop_lat_r || stop;

    assign bus.tx_valid = tx_valid_r;
    assign bus.tx_data  = tx_data_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign frame_cnt    = frame_cnt_r;
    assign sta          = state_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; GAP lasts max(gap_cycles, 1) cycles.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: state_nx_s = ST_SEND;
            ST_SEND: begin
                if (xfer_s && last_s) begin
                    if (repeat_en && !stop_any_s) begin
                        state_nx_s = ST_GAP;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (stop_any_s) begin
                    state_nx_s = ST_DONE;
                end else if (gap_cnt_r <= GAP_W'(1)) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Datapath: frame shift register, byte output, gap/frame counters, stop latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r     <= '0;
            byte_idx_r  <= '0;
            gap_cnt_r   <= '0;
            stop_lat_r  <= 1'b0;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            done_r <= (state_nx_s == ST_DONE);
            busy_r <= (state_nx_s != ST_IDLE);

            if (state_r == ST_IDLE) begin
                if (start) begin
                    stop_lat_r <= 1'b0;
                end
            end else if (stop) begin
                stop_lat_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    tx_valid_r <= 1'b0;
                    if (start) begin
                        shift_r     <= frame_in;
                        frame_cnt_r <= '0;
                    end
                end
                ST_LOAD: begin
                    tx_valid_r <= 1'b1;
                    tx_data_r  <= shift_r[FW-1 -: 8];
                    byte_idx_r <= '0;
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        if (last_s) begin
                            tx_valid_r  <= 1'b0;
                            frame_cnt_r <= frame_cnt_r + CNT_W'(1);
                            gap_cnt_r   <= gap_cycles;
                        end else begin
                            tx_data_r  <= shift_r[FW-9 -: 8];
                            shift_r    <= {shift_r[FW-9:0], 8'h00};
                            byte_idx_r <= byte_idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    tx_valid_r <= 1'b0;
                    if (state_nx_s == ST_LOAD) begin
                        shift_r <= frame_in;
                    end
                    if (gap_cnt_r != GAP_W'(0)) begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end
                end
                ST_DONE: tx_valid_r <= 1'b0;
                default: tx_valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sender.sv
// Randomised self-checking bench for uart_frame_sender; expected byte streams come
// from a frame-to-bytes reference model, timing from the documented cycle rules.
module tb_uart_frame_sender;

    localparam int NB = 5;
    localparam int GW = 16;
    localparam int CW = 16;
    localparam int FW = 8 * NB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          repeat_en = 1'b0;
    logic [GW-1:0] gap_cycles = '0;
    logic [FW-1:0] frame_in = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] frame_cnt;
    logic [2:0]    sta;

    int tests_run = 0;
    int fails = 0;

    uart_frame_sender_if bif();

    uart_frame_sender #(.NBYTES(NB), .GAP_W(GW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .repeat_en(repeat_en),
        .gap_cycles(gap_cycles), .frame_in(frame_in), .bus(bif),
        .busy(busy), .done(done), .frame_cnt(frame_cnt), .sta(sta)
    );

    always #5 clk = ~clk;

    // Monitor log: transferred bytes with the edge index they moved on.
    int         cyc = 0;
    logic [7:0] got_q[$];
    int         got_t[$];
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         hold_err = 0;
    int         valid_err = 0;
    int         ready_mode = 0;   // 0 always ready, 1 pattern 1-0-0-1, 2 random, 3 stalled

    initial begin
        logic       hold_pend;
        logic [7:0] hold_data;
        hold_pend = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(posedge clk);
            if (hold_pend && rst && (bif.tx_valid !== 1'b1 || bif.tx_data !== hold_data)) hold_err++;
            hold_pend = rst && (bif.tx_valid === 1'b1) && (bif.tx_ready !== 1'b1);
            hold_data = bif.tx_data;
            if (bif.tx_valid === 1'b1 && bif.tx_ready === 1'b1) begin
                got_q.push_back(bif.tx_data);
                got_t.push_back(cyc);
            end
            if (done === 1'b1) done_cnt++;
            if (bif.tx_valid === 1'b1 && sta !== 3'd2) valid_err++;
            cyc++;
        end
    end

    initial begin
        bif.tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: bif.tx_ready = 1'b1;
                1: bif.tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2: bif.tx_ready = 1'($urandom_range(0, 1));
                default: bif.tx_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d bytes", got_q.size());
        $fatal(1);
    end

    // Reference model: a frame is sent as its bytes from most to least significant.
    function automatic void add_frame(input logic [FW-1:0] f);
        for (int i = NB - 1; i >= 0; i--) exp_q.push_back(f[8*i +: 8]);
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        return r64[FW-1:0];
    endfunction

    task automatic clear_log();
        got_q.delete(); got_t.delete(); exp_q.delete();
        done_cnt = 0; hold_err = 0; valid_err = 0;
    endtask

    task automatic pulse_start(output int s_edge);
        start = 1'b1;
        s_edge = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_xfers(input int n, input int budget, output bit ok);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (done_cnt > 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        tests_run++; if (bif.tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", bif.tx_valid); end
        tests_run++; if (bif.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", bif.tx_data); end
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        tests_run++; if (sta !== 3'd0) begin fails++; $display("FAIL reset_sta got %0d want 0", sta); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int s_edge;
        bit ok;
        ready_mode = 0; repeat_en = 1'b0;
        @(negedge clk);
        clear_log();
        frame_in = 40'h0000FCF9E7;
        add_frame(frame_in);
        pulse_start(s_edge);
        wait_done(100, ok);
        repeat (3) @(negedge clk);
        tests_run++; if (!ok) begin fails++; $display("FAIL single_timeout no done pulse"); end
        tests_run++; if (got_q.size() != 5) begin fails++; $display("FAIL single_count got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL single_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
            tests_run++; if (got_t[i] != s_edge + 2 + i) begin fails++; $display("FAIL single_time%0d got %0d want %0d", i, got_t[i], s_edge + 2 + i); end
        end
        tests_run++; if (done_cnt != 1) begin fails++; $display("FAIL single_done got %0d want 1", done_cnt); end
        tests_run++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
        tests_run++; if (busy !== 1'b0 || sta !== 3'd0) begin fails++; $display("FAIL single_idle busy %b sta %0d want 0 0", busy, sta); end
        tests_run++; if (valid_err != 0) begin fails++; $display("FAIL single_valid_outside_send got %0d want 0", valid_err); end
    endtask

    task automatic test_ready_toggle();
        int s_edge;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            ready_mode = (it < 2) ? 1 : 2;
            @(negedge clk);
            clear_log();
            frame_in = (it == 0) ? 40'h0000FCF9E7 : rand_frame();
            add_frame(frame_in);
            pulse_start(s_edge);
            wait_done(200, ok);
            repeat (2) @(negedge clk);
            tests_run++; if (!ok || got_q.size() != 5) begin fails++; $display("FAIL toggle%0d_count got %0d want 5", it, got_q.size()); end
            for (int i = 0; i < 5 && i < got_q.size(); i++) begin
                tests_run++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL toggle%0d_byte%0d got %h want %h", it, i, got_q[i], exp_q[i]); end
            end
            tests_run++; if (hold_err != 0) begin fails++; $display("FAIL toggle%0d_hold got %0d unstable stalls want 0", it, hold_err); end
            tests_run++; if (frame_cnt !== 16'd1 || done_cnt != 1) begin fails++; $display("FAIL toggle%0d_end frame_cnt %0d done %0d want 1 1", it, frame_cnt, done_cnt); end
        end
    endtask

    task automatic test_repeat_gap();
        int s_edge;
        bit ok1, ok2, ok3;
        ready_mode = 0; repeat_en = 1'b1; gap_cycles = 16'd3;
        @(negedge clk);
        clear_log();
        frame_in = 40'h0000FCF9E7;
        add_frame(40'h0000FCF9E7);
        add_frame(40'h0102030405);
        pulse_start(s_edge);
        wait_xfers(5, 100, ok1);
        frame_in = 40'h0102030405;
        tests_run++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL repeat_cnt1 got %0d want 1", frame_cnt); end
        wait_xfers(10, 100, ok2);
        tests_run++; if (frame_cnt !== 16'd2) begin fails++; $display("FAIL repeat_cnt2 got %0d want 2", frame_cnt); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(50, ok3);
        repeat (3) @(negedge clk);
        repeat_en = 1'b0;
        tests_run++; if (!(ok1 && ok2 && ok3)) begin fails++; $display("FAIL repeat_timeout flags %b%b%b want 111", ok1, ok2, ok3); end
        tests_run++; if (got_q.size() != 10) begin fails++; $display("FAIL repeat_count got %0d want 10", got_q.size()); end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL repeat_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_t.size() >= 6) begin
            tests_run++; if (got_t[5] - got_t[4] != 5) begin fails++; $display("FAIL repeat_gap got %0d edges want 5", got_t[5] - got_t[4]); end
        end
        tests_run++; if (frame_cnt !== 16'd2 || done_cnt != 1 || busy !== 1'b0) begin fails++; $display("FAIL repeat_end frame_cnt %0d done %0d busy %b want 2 1 0", frame_cnt, done_cnt, busy); end
    endtask

    task automatic test_stop_mid();
        int s_edge;
        bit ok1, ok2;
        logic [FW-1:0] f;
        ready_mode = 2; repeat_en = 1'b1; gap_cycles = GW'($urandom_range(1, 4));
        @(negedge clk);
        clear_log();
        f = rand_frame();
        frame_in = f;
        for (int k = 0; k < 3; k++) add_frame(f);
        pulse_start(s_edge);
        wait_xfers(11, 400, ok1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(200, ok2);
        repeat (10) @(negedge clk);
        repeat_en = 1'b0;
        tests_run++; if (!(ok1 && ok2)) begin fails++; $display("FAIL stop_timeout flags %b%b want 11", ok1, ok2); end
        tests_run++; if (got_q.size() != 15) begin fails++; $display("FAIL stop_count got %0d want 15", got_q.size()); end
        for (int i = 0; i < 15 && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL stop_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests_run++; if (frame_cnt !== 16'd3) begin fails++; $display("FAIL stop_frame_cnt got %0d want 3", frame_cnt); end
        tests_run++; if (done_cnt != 1) begin fails++; $display("FAIL stop_done got %0d want 1", done_cnt); end
        tests_run++; if (hold_err != 0 || valid_err != 0) begin fails++; $display("FAIL stop_protocol hold %0d valid %0d want 0 0", hold_err, valid_err); end
    endtask

    task automatic test_reset_mid();
        int s_edge;
        bit ok;
        ready_mode = 0; repeat_en = 1'b1; gap_cycles = 16'd1;
        @(negedge clk);
        clear_log();
        frame_in = rand_frame();
        pulse_start(s_edge);
        wait_xfers(8, 100, ok);
        ready_mode = 3;
        repeat (3) @(negedge clk);
        tests_run++; if (!ok || frame_cnt !== 16'd1 || bif.tx_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre frame_cnt %0d tx_valid %b want 1 1", frame_cnt, bif.tx_valid); end
        rst = 1'b0;
        #1;
        tests_run++; if (bif.tx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_tx_valid got %b want 0", bif.tx_valid); end
        tests_run++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_frame_cnt got %0d want 0", frame_cnt); end
        tests_run++; if (sta !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_state sta %0d busy %b want 0 0", sta, busy); end
        @(negedge clk);
        rst = 1'b1; repeat_en = 1'b0; ready_mode = 0;
        clear_log();
        repeat (5) @(negedge clk);
        tests_run++; if (got_q.size() != 0 || sta !== 3'd0) begin fails++; $display("FAIL rstmid_quiet bytes %0d sta %0d want 0 0", got_q.size(), sta); end
        frame_in = rand_frame();
        add_frame(frame_in);
        pulse_start(s_edge);
        wait_done(100, ok);
        repeat (2) @(negedge clk);
        tests_run++; if (!ok || got_q.size() != 5) begin fails++; $display("FAIL rstmid_clean_count got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rstmid_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_t.size() > 0) begin
            tests_run++; if (got_t[0] != s_edge + 2) begin fails++; $display("FAIL rstmid_latency got %0d want %0d", got_t[0], s_edge + 2); end
        end
        tests_run++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL rstmid_clean_cnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_busy_start_gap0();
        int s_edge;
        int k;
        bit ok;
        logic [FW-1:0] f;
        ready_mode = 0; repeat_en = 1'b1; gap_cycles = 16'd0;
        @(negedge clk);
        clear_log();
        f = rand_frame();
        frame_in = f;
        for (int j = 0; j < 3; j++) add_frame(f);
        pulse_start(s_edge);
        k = 0;
        while (got_q.size() < 11 && k < 300) begin
            start = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(100, ok);
        repeat (5) @(negedge clk);
        repeat_en = 1'b0;
        tests_run++; if (!ok || got_q.size() != 15) begin fails++; $display("FAIL gap0_count got %0d want 15", got_q.size()); end
        for (int i = 0; i < 15 && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL gap0_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_t.size() >= 11) begin
            tests_run++; if (got_t[5] - got_t[4] != 3) begin fails++; $display("FAIL gap0_sep1 got %0d edges want 3", got_t[5] - got_t[4]); end
            tests_run++; if (got_t[10] - got_t[9] != 3) begin fails++; $display("FAIL gap0_sep2 got %0d edges want 3", got_t[10] - got_t[9]); end
        end
        tests_run++; if (frame_cnt !== 16'd3 || done_cnt != 1) begin fails++; $display("FAIL gap0_end frame_cnt %0d done %0d want 3 1", frame_cnt, done_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ready_toggle();
        test_repeat_gap();
        test_stop_mid();
        test_reset_mid();
        test_busy_start_gap0();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
